// File: rtl/hacd_decompressor_if.sv
// ----------------------------------------------------------------------------
// hacd_decompressor_if
// FIFO-side bundle for the HACD page decompressor.
//   Read side : rdfifo_empty, rd_req, rd_data, rd_rresp, rd_valid
//   Write side: wrfifo_full, wr_req, wr_data
// modport master = decompressor side, modport slave = FIFO side.
// ----------------------------------------------------------------------------
interface hacd_decompressor_if #(
    parameter int DATA_WIDTH = 512
) ();
    logic                  rdfifo_empty;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_rresp;
    logic                  rd_valid;
    logic                  wrfifo_full;
    logic                  wr_req;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        input  rdfifo_empty, rd_data, rd_rresp, rd_valid, wrfifo_full,
        output rd_req, wr_req, wr_data
    );

    modport slave (
        output rdfifo_empty, rd_data, rd_rresp, rd_valid, wrfifo_full,
        input  rd_req, wr_req, wr_data
    );
endinterface

// File: rtl/hacd_decompressor.sv
// ----------------------------------------------------------------------------
// hacd_decompressor
// Rebuilds a 64-cacheline page from one metadata line plus 16 payload lines.
// Chunks flagged in the metadata zero-vector are written as all-zero lines;
// the single non-zero chunk is copied from the payload stream.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   decomp_start       level request to decompress one page
//   fifo (master)      read-FIFO / write-FIFO handshake bundle
//   decomp_done        page fully written (held until decomp_start drops)
//   bus_error          sticky, nonzero read response seen
//   fmt_error          sticky, invalid metadata seen
//   dbg_state          current FSM state
//   dbg_line_cnt       output line counter
//
// Optional feature macro: HACD_DECOMP_STRICT_META_EN
//   defined   -> metadata bits above [3:0] must be zero, else format error
//   undefined -> those bits are ignored
// ----------------------------------------------------------------------------
module hacd_decompressor #(
    parameter int DATA_WIDTH      = 512,
    parameter int LINES_PER_CHUNK = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       decomp_start,
    hacd_decompressor_if.master        fifo,
    output logic                       decomp_done,
    output logic                       bus_error,
    output logic                       fmt_error,
    output logic [2:0]                 dbg_state,
    output logic [6:0]                 dbg_line_cnt
);

    localparam int PAGE_LINES = 4 * LINES_PER_CHUNK;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_META = 3'd1,
        EXPAND  = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4,
        BUS_ERR = 3'd5,
        FMT_ERR = 3'd6
    } state_e;

    state_e     state;
    logic [6:0] line_cnt;
    logic [4:0] drain_cnt;
    logic [3:0] meta_zv;
    logic [1:0] pay_chunk;
    logic       outstanding;

    // A zero-vector is usable when it flags all four chunks or all but one.
    function automatic logic meta_fmt_ok(input logic [3:0] zv);
        case (zv)
            4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] zero_idx(input logic [3:0] zv);
        case (zv)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    logic       rsp_vld;
    logic       rsp_err;
    logic       rd_ok;
    logic [1:0] cur_chunk;
    logic       in_payload;
    logic       meta_ok;

    // Responses are only honoured while a read is actually in flight.
    assign rsp_vld    = fifo.rd_valid && outstanding;
    assign rsp_err    = (fifo.rd_rresp != 2'b00);
    assign rd_ok      = !fifo.rdfifo_empty && !outstanding;
    assign cur_chunk  = 2'(line_cnt / 7'(LINES_PER_CHUNK));
    assign in_payload = (cur_chunk == pay_chunk) && (meta_zv != 4'hF);

`ifdef HACD_DECOMP_STRICT_META_EN
    assign meta_ok = meta_fmt_ok(fifo.rd_data[3:0]) &&
                     (fifo.rd_data[DATA_WIDTH-1:4] == '0);
`else
    assign meta_ok = meta_fmt_ok(fifo.rd_data[3:0]);
`endif

    assign dbg_state    = state;
    assign dbg_line_cnt = line_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            line_cnt     <= '0;
            drain_cnt    <= '0;
            meta_zv      <= '0;
            pay_chunk    <= '0;
            outstanding  <= 1'b0;
            fifo.rd_req  <= 1'b0;
            fifo.wr_req  <= 1'b0;
            fifo.wr_data <= '0;
            decomp_done  <= 1'b0;
            bus_error    <= 1'b0;
            fmt_error    <= 1'b0;
        end else begin
            fifo.rd_req <= 1'b0;
            fifo.wr_req <= 1'b0;
            if (rsp_vld) begin
                outstanding <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (decomp_start && !fifo.rdfifo_empty) begin
                        state     <= RD_META;
                        line_cnt  <= '0;
                        drain_cnt <= '0;
                    end
                end

                RD_META: begin
                    if (rsp_vld) begin
                        if (rsp_err) begin
                            state     <= BUS_ERR;
                            bus_error <= 1'b1;
                        end else begin
                            meta_zv   <= fifo.rd_data[3:0];
                            pay_chunk <= zero_idx(fifo.rd_data[3:0]);
                            if (meta_ok) begin
                                state <= EXPAND;
                            end else begin
                                state     <= FMT_ERR;
                                fmt_error <= 1'b1;
                            end
                        end
                    end else if (rd_ok) begin
                        fifo.rd_req <= 1'b1;
                        outstanding <= 1'b1;
                    end
                end

                EXPAND: begin
                    if (line_cnt == 7'(PAGE_LINES)) begin
                        // An all-zero page still owns 16 payload lines in the FIFO.
                        if (meta_zv == 4'hF) begin
                            state <= DRAIN;
                        end else begin
                            state       <= DONE;
                            decomp_done <= 1'b1;
                        end
                    end else if (in_payload) begin
                        if (rsp_vld) begin
                            if (rsp_err) begin
                                state     <= BUS_ERR;
                                bus_error <= 1'b1;
                            end else begin
                                // Written even if the FIFO went almost-full meanwhile;
                                // its slack entry absorbs this line.
                                fifo.wr_req  <= 1'b1;
                                fifo.wr_data <= fifo.rd_data;
                                line_cnt     <= line_cnt + 7'd1;
                            end
                        end else if (rd_ok && !fifo.wrfifo_full) begin
                            fifo.rd_req <= 1'b1;
                            outstanding <= 1'b1;
                        end
                    end else if (!fifo.wrfifo_full) begin
                        fifo.wr_req  <= 1'b1;
                        fifo.wr_data <= '0;
                        line_cnt     <= line_cnt + 7'd1;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == 5'(LINES_PER_CHUNK)) begin
                        state       <= DONE;
                        decomp_done <= 1'b1;
                    end else if (rsp_vld) begin
                        if (rsp_err) begin
                            state     <= BUS_ERR;
                            bus_error <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 5'd1;
                        end
                    end else if (rd_ok) begin
                        fifo.rd_req <= 1'b1;
                        outstanding <= 1'b1;
                    end
                end

                DONE: begin
                    if (!decomp_start) begin
                        state       <= IDLE;
                        decomp_done <= 1'b0;
                    end
                end

                BUS_ERR, FMT_ERR: begin
                    state <= state;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hacd_decompressor.sv
module tb_hacd_decompressor;

    localparam int DW = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       decomp_start = 1'b0;
    logic       decomp_done;
    logic       bus_error;
    logic       fmt_error;
    logic [2:0] dbg_state;
    logic [6:0] dbg_line_cnt;

    hacd_decompressor_if #(.DATA_WIDTH(DW)) fifo_if ();

    hacd_decompressor #(.DATA_WIDTH(DW), .LINES_PER_CHUNK(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .decomp_start (decomp_start),
        .fifo         (fifo_if),
        .decomp_done  (decomp_done),
        .bus_error    (bus_error),
        .fmt_error    (fmt_error),
        .dbg_state    (dbg_state),
        .dbg_line_cnt (dbg_line_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // FIFO model configuration and observations
    logic [DW-1:0] cfg_meta = '0;
    int            cfg_err_at = -1;
    bit            cfg_flow = 1'b0;
    int            rd_cnt = 0;
    int            rdreq_cnt = 0;
    int            wr_cnt = 0;
    int            full_viol = 0;
    int            empty_viol = 0;
    int            done_seen = 0;
    int            cyc = 0;
    bit            pend = 1'b0;
    bit            prev_full = 1'b0;
    bit            prev_rdv = 1'b0;
    bit            prev_empty = 1'b0;
    logic [DW-1:0] got [64];

    function automatic logic [DW-1:0] pay_line(input int i);
        logic [DW-1:0] v;
        v = DW'(i);
        v = v | (DW'(i) << 500);
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_line(input logic [3:0] zv, input int l);
        if (zv[l / 16]) return '0;
        return pay_line((l % 16) + 1);
    endfunction

    // Read FIFO returns data one cycle after it sees rd_req; write FIFO is a sink.
    initial begin
        fifo_if.rd_valid     = 1'b0;
        fifo_if.rd_data      = '0;
        fifo_if.rd_rresp     = 2'b00;
        fifo_if.rdfifo_empty = 1'b0;
        fifo_if.wrfifo_full  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (fifo_if.wr_req) begin
                if (wr_cnt < 64) got[wr_cnt] = fifo_if.wr_data;
                wr_cnt++;
                if (prev_full && !prev_rdv) full_viol++;
            end
            if (fifo_if.rd_req) begin
                rdreq_cnt++;
                if (prev_empty) empty_viol++;
            end
            if (decomp_done) done_seen++;
            if (pend) begin
                fifo_if.rd_valid = 1'b1;
                fifo_if.rd_data  = (rd_cnt == 0) ? cfg_meta : pay_line(rd_cnt);
                fifo_if.rd_rresp = (rd_cnt == cfg_err_at) ? 2'd2 : 2'd0;
                rd_cnt++;
            end else begin
                fifo_if.rd_valid = 1'b0;
                fifo_if.rd_rresp = 2'd0;
            end
            pend = fifo_if.rd_req;
            if (cfg_flow) begin
                fifo_if.wrfifo_full  = ((cyc / 3) % 2) == 1;
                fifo_if.rdfifo_empty = ($urandom_range(0, 2) == 0);
            end else begin
                fifo_if.wrfifo_full  = 1'b0;
                fifo_if.rdfifo_empty = 1'b0;
            end
            prev_full  = fifo_if.wrfifo_full;
            prev_rdv   = fifo_if.rd_valid;
            prev_empty = fifo_if.rdfifo_empty;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        decomp_start = 1'b0;
        cfg_flow = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_page(input logic [DW-1:0] meta, input int err_at, input bit flow);
        @(negedge clk);
        cfg_meta   = meta;
        cfg_err_at = err_at;
        cfg_flow   = flow;
        rd_cnt     = 0;
        rdreq_cnt  = 0;
        wr_cnt     = 0;
        full_viol  = 0;
        empty_viol = 0;
        done_seen  = 0;
        decomp_start = 1'b1;
    endtask

    task automatic wait_end(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done_seen > 0 || bus_error || fmt_error) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (fifo_if.rd_req !== 1'b0) begin fails++; $display("FAIL reset_rd_req got %b want 0", fifo_if.rd_req); end
        tests++; if (fifo_if.wr_req !== 1'b0) begin fails++; $display("FAIL reset_wr_req got %b want 0", fifo_if.wr_req); end
        tests++; if (fifo_if.wr_data !== '0) begin fails++; $display("FAIL reset_wr_data got %h want 0", fifo_if.wr_data); end
        tests++; if ({decomp_done, bus_error, fmt_error} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {decomp_done, bus_error, fmt_error}); end
        tests++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        tests++; if (dbg_line_cnt !== 7'd0) begin fails++; $display("FAIL reset_line_cnt got %0d want 0", dbg_line_cnt); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL idle_no_start got %0d want 0", dbg_state); end
    endtask

    // Runs a full page and checks the written stream against the zero-vector.
    task automatic run_good_page(input string nm, input logic [DW-1:0] meta, input bit flow,
                                 input bit early_drop);
        bit ok;
        start_page(meta, -1, flow);
        if (early_drop) begin
            repeat (5) @(negedge clk);
            decomp_start = 1'b0;
        end
        wait_end(4000, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL %s_timeout got %b want 1", nm, ok); end
        repeat (3) @(negedge clk);
        tests++; if (wr_cnt !== 64) begin fails++; $display("FAIL %s_wr_count got %0d want 64", nm, wr_cnt); end
        tests++; if (rdreq_cnt !== 17) begin fails++; $display("FAIL %s_rd_count got %0d want 17", nm, rdreq_cnt); end
        tests++; if ({bus_error, fmt_error} !== 2'b00) begin fails++; $display("FAIL %s_err_flags got %b want 00", nm, {bus_error, fmt_error}); end
        tests++; if (full_viol !== 0) begin fails++; $display("FAIL %s_write_while_full got %0d want 0", nm, full_viol); end
        tests++; if (empty_viol !== 0) begin fails++; $display("FAIL %s_read_while_empty got %0d want 0", nm, empty_viol); end
        for (int l = 0; l < 64; l++) begin
            tests++;
            if (got[l] !== exp_line(meta[3:0], l)) begin
                fails++;
                $display("FAIL %s_line%0d got %h want %h", nm, l, got[l], exp_line(meta[3:0], l));
            end
        end
        if (!early_drop) begin
            tests++; if (decomp_done !== 1'b1) begin fails++; $display("FAIL %s_done_held got %b want 1", nm, decomp_done); end
            tests++; if (dbg_state !== 3'd4) begin fails++; $display("FAIL %s_done_state got %0d want 4", nm, dbg_state); end
            decomp_start = 1'b0;
            @(negedge clk);
        end
        cfg_flow = 1'b0;
        @(negedge clk);
        tests++; if (decomp_done !== 1'b0) begin fails++; $display("FAIL %s_done_drop got %b want 0", nm, decomp_done); end
        tests++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL %s_back_idle got %0d want 0", nm, dbg_state); end
    endtask

    task automatic test_chunk0();
        run_good_page("chunk0", DW'(4'b1110), 1'b0, 1'b0);
    endtask

    task automatic test_chunk3_start_drop();
        run_good_page("chunk3", DW'(4'b0111), 1'b0, 1'b1);
    endtask

    task automatic test_all_zero();
        run_good_page("allzero", DW'(4'b1111), 1'b0, 1'b0);
        tests++; if (rd_cnt !== 17) begin fails++; $display("FAIL allzero_drained got %0d want 17", rd_cnt); end
    endtask

    task automatic test_flow_control();
        run_good_page("flow", DW'(4'b1101), 1'b1, 1'b0);
    endtask

    task automatic test_fmt_error();
        bit ok;
        start_page(DW'(4'b1100), -1, 1'b0);
        wait_end(200, ok);
        repeat (20) @(negedge clk);
        tests++; if (fmt_error !== 1'b1) begin fails++; $display("FAIL fmt_flag got %b want 1", fmt_error); end
        tests++; if (bus_error !== 1'b0) begin fails++; $display("FAIL fmt_bus_flag got %b want 0", bus_error); end
        tests++; if (dbg_state !== 3'd6) begin fails++; $display("FAIL fmt_state got %0d want 6", dbg_state); end
        tests++; if (wr_cnt !== 0) begin fails++; $display("FAIL fmt_wr_count got %0d want 0", wr_cnt); end
        tests++; if (rdreq_cnt !== 1) begin fails++; $display("FAIL fmt_rd_count got %0d want 1", rdreq_cnt); end
        do_reset();
        tests++; if (fmt_error !== 1'b0) begin fails++; $display("FAIL fmt_reset_clear got %b want 0", fmt_error); end
    endtask

    task automatic test_bus_error();
        bit ok;
        start_page(DW'(4'b1110), 5, 1'b0);
        wait_end(500, ok);
        repeat (20) @(negedge clk);
        tests++; if (bus_error !== 1'b1) begin fails++; $display("FAIL bus_flag got %b want 1", bus_error); end
        tests++; if (fmt_error !== 1'b0) begin fails++; $display("FAIL bus_fmt_flag got %b want 0", fmt_error); end
        tests++; if (dbg_state !== 3'd5) begin fails++; $display("FAIL bus_state got %0d want 5", dbg_state); end
        tests++; if (wr_cnt !== 4) begin fails++; $display("FAIL bus_wr_count got %0d want 4", wr_cnt); end
        tests++; if (rdreq_cnt !== 6) begin fails++; $display("FAIL bus_rd_count got %0d want 6", rdreq_cnt); end
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (got[l] !== pay_line(l + 1)) begin
                fails++;
                $display("FAIL bus_line%0d got %h want %h", l, got[l], pay_line(l + 1));
            end
        end
        do_reset();
        tests++; if (bus_error !== 1'b0) begin fails++; $display("FAIL bus_reset_clear got %b want 0", bus_error); end
        tests++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL bus_reset_state got %0d want 0", dbg_state); end
    endtask

    task automatic test_strict_meta();
        logic [DW-1:0] m;
        m = DW'(12'h10E);
`ifdef HACD_DECOMP_STRICT_META_EN
        begin
            bit ok;
            start_page(m, -1, 1'b0);
            wait_end(200, ok);
            repeat (10) @(negedge clk);
            tests++; if (fmt_error !== 1'b1) begin fails++; $display("FAIL strict_fmt got %b want 1", fmt_error); end
            tests++; if (wr_cnt !== 0) begin fails++; $display("FAIL strict_wr_count got %0d want 0", wr_cnt); end
            do_reset();
        end
`else
        run_good_page("loose", m, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_chunk0();
        test_chunk3_start_drop();
        test_all_zero();
        test_fmt_error();
        test_bus_error();
        test_flow_control();
        test_strict_meta();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hacd_decompressor.md
Name: hacd_decompressor

Overview:
- Inverse of the HACD zero-chunk page compressor; sits between the compressed-page read FIFO and the decompressed-page write FIFO in the HACD comp/decomp path.
- Reads one metadata cacheline plus 16 payload cachelines, then rebuilds a 64-cacheline page in order.
- Chunks flagged zero are emitted as all-zero lines. The single non-zero chunk is filled from the payload.

Parameters:
- DATA_WIDTH, 512, cacheline width in bits (equals HACD_AXI4_DATA_WIDTH).
- LINES_PER_CHUNK, 16, cachelines per chunk; page = 4 chunks = 64 lines.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- decomp_start  in  1  level; requests decompression of one page.
- rdfifo_empty  in  1  compressed-data read FIFO empty.
- rd_req  out  1  one-cycle read pulse to the read FIFO.
- rd_data  in  DATA_WIDTH  returned cacheline.
- rd_rresp  in  2  response code; 0 = OKAY.
- rd_valid  in  1  rd_data/rd_rresp valid for one cycle.
- wrfifo_full  in  1  write FIFO almost-full; guarantees ≥1 entry of slack.
- wr_req  out  1  one-cycle write pulse.
- wr_data  out  DATA_WIDTH  decompressed cacheline.
- decomp_done  out  1  page fully written.
- bus_error  out  1  sticky; a nonzero rd_rresp was seen.
- fmt_error  out  1  sticky; invalid metadata.
- dbg_state  out  3  current FSM state.
- dbg_line_cnt  out  7  output line counter.

Behaviour:
- Reset values: all outputs 0; state IDLE; line_cnt 0; meta 0; outstanding 0.
- Asserting rst_ni mid-operation aborts the page immediately. No partial-state recovery.
- Outputs are registered: wr_req, wr_data, rd_req are driven one cycle after the decision cycle.
- Read handshake:
  - At most one read outstanding.
  - rd_req is issued only when !rdfifo_empty && !outstanding (and, in EXPAND, also !wrfifo_full).
  - outstanding is set with rd_req and cleared on rd_valid.
  - rd_valid with no read outstanding is ignored.
- Metadata format: bits[3:0] = zero_chunk_vec; bit i = 1 means chunk i (lines 16i..16i+15) is all zero.
- Metadata validity:
  - Exactly one 0 bit: valid. Payload chunk p is the index of that bit.
  - 4'b1111: valid all-zero page. Payload is still consumed and then discarded.
  - Two or more 0 bits: invalid → FMT_ERROR.
- States:
  - IDLE: decomp_start && !rdfifo_empty → RD_META; clear line_cnt.
  - RD_META: issue one read. On rd_valid:
    - rresp≠0 → BUS_ERROR.
    - otherwise latch meta, then valid → EXPAND, invalid → FMT_ERROR.
  - EXPAND: line l = line_cnt, chunk = l[5:4].
    - If chunk == p and meta ≠ 1111: issue a read. On rd_valid with rresp 0, write rd_data and increment l. On rresp≠0 → BUS_ERROR.
    - Otherwise, when !wrfifo_full: write 0 and increment l.
    - When l == 64: meta == 1111 → DRAIN, else → DONE.
  - DRAIN: read 16 lines and discard; no writes. Count complete → DONE. rresp≠0 → BUS_ERROR.
  - DONE: decomp_done = 1. Stay while decomp_start is high; when it drops → IDLE and decomp_done drops the next cycle.
  - BUS_ERROR / FMT_ERROR: terminal until reset. The matching sticky flag is high. No further rd_req/wr_req.
- Write stream: exactly 64 wr_req pulses per page, lines 0..63 in order, with no gaps other than those forced by FIFO flow control.
- Simultaneous events:
  - rd_valid together with wrfifo_full in EXPAND: the write is still performed (guaranteed by the slack entry). No new read is issued until !wrfifo_full.
  - decomp_start deasserted mid-page: ignored; the page completes.

Optional Feature:
- HACD_DECOMP_STRICT_META_EN
  - Defined: metadata bits[DATA_WIDTH-1:4] ≠ 0 → FMT_ERROR.
  - Undefined: those bits are ignored.

Test Plan:
- meta = 4'b1110, payload lines = 0x1..0x10 → lines 0–15 = 0x1..0x10; lines 16–63 = 0; 64 wr_req; then decomp_done.
- meta = 4'b0111 → lines 0–47 = 0; lines 48–63 = payload; rd_req count = 17.
- meta = 4'b1111 → 64 zero lines; then 16 drained reads with no writes; rd_req count = 17; decomp_done.
- meta = 4'b1100 → fmt_error = 1; zero wr_req; no further rd_req.
- rresp = 2 on 5th payload read → exactly 4 payload writes; bus_error = 1 sticky; reset clears it.
- wrfifo_full toggled every 3 cycles and rdfifo_empty randomized → same 64-line output; no write issued while full except the in-flight one.
- Build with HACD_DECOMP_STRICT_META_EN, meta = 0x10E → fmt_error. Without the macro, same input → normal decompress.
